spi_per: RTL and testbench

SPI_PER -- requirements
Module: spi_per

---
 rtl/spi_per.sv | 201 ++++++++++++++++++++
 tb/tb_spi_per.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_per.sv
// spi_per: SPI mode-0 peripheral (MSB first) running entirely in the clk_in
// domain. The controller's DCLK, CS and COPI are oversampled through
// synchronizer chains, and edges are found by comparing each synchronized
// value with a copy delayed by one cycle.
//
// Host-side handshake: there is no backpressure on either side.
// - tx_load_in is a single-cycle strobe. It always writes the TX buffer and
//   clears tx_empty_out.
// - rx_valid_out is a single-cycle pulse that qualifies rx_data_out on the
//   cycle it updates. The host must take the word then, or lose it when the
//   next word completes.
// The TX buffer is consumed when a word starts: on CS fall, and after every
// completed word while CS stays low. Consuming an empty buffer sends zeros.
module spi_per #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_load_in,
  output logic                  tx_empty_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  abort_out,
  output logic                  busy_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  output logic                  chip_data_oe_out
);

  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [DATA_WIDTH-1:0]   tx_buf;

  logic [SYNC_STAGES-1:0]  dclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  copi_sync;
  logic                    dclk_d;
  logic                    cs_d;
  logic [FLUSH_W-1:0]      flush_cnt;
  logic                    cs_armed;

  logic                    dclk_s;
  logic                    cs_s;
  logic                    copi_s;
  logic                    dclk_rise;
  logic                    dclk_fall;
  logic                    cs_fall;
  logic                    cs_rise;
  logic                    word_start;
  logic                    word_end;
  logic                    consume;
  logic [DATA_WIDTH-1:0]   tx_next_word;
  logic [DATA_WIDTH-1:0]   rx_next;

  // Synchronizer chains for the three controller inputs; CS idles high
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dclk_sync <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], chip_clk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_sel_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], chip_data_in};
    end
  end

  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];

  // One-cycle delayed copies used for edge detection
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      dclk_d <= dclk_s;
      cs_d   <= cs_s;
    end
  end

  // After reset, accept a CS fall only once CS has really been seen high.
  // Otherwise a CS held low across reset would look like a fresh fall as
  // the synchronizer flushes its reset value out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      flush_cnt <= '0;
      cs_armed  <= 1'b0;
    end else if (flush_cnt != FLUSH_W'(SYNC_STAGES + 1)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end else if (cs_s && cs_d) begin
      cs_armed <= 1'b1;
    end
  end

  assign dclk_rise = dclk_s & ~dclk_d;
  assign dclk_fall = ~dclk_s & dclk_d;
  assign cs_fall   = cs_armed & ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // A word starts on CS fall, or when the last bit of a word is sampled
  // while CS is still low (back-to-back burst).
  assign word_start   = (state == IDLE) && cs_fall;
  assign word_end     = (state == ACTIVE) && !cs_rise && dclk_rise &&
                        (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign consume      = word_start || word_end;
  assign tx_next_word = tx_empty_out ? '0 : tx_buf;
  assign rx_next      = {rx_shift[DATA_WIDTH-2:0], copi_s};

  // TX buffer: a load always wins over a same-cycle consume. The consumer
  // reads tx_buf as it stood before this edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_buf       <= '0;
      tx_empty_out <= 1'b1;
    end else if (tx_load_in) begin
      tx_buf       <= tx_data_in;
      tx_empty_out <= 1'b0;
    end else if (consume) begin
      tx_empty_out <= 1'b1;
    end
  end

  // Main FSM: CS framing, bit counting, RX/TX shifting and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      tx_shift         <= '0;
      rx_shift         <= '0;
      rx_data_out      <= '0;
      rx_valid_out     <= 1'b0;
      abort_out        <= 1'b0;
      busy_out         <= 1'b0;
      chip_data_out    <= 1'b0;
      chip_data_oe_out <= 1'b0;
    end else begin
      rx_valid_out <= 1'b0;
      abort_out    <= 1'b0;
      case (state)
        IDLE: begin
          // DCLK activity is ignored until the controller selects us
          if (cs_fall) begin
            state            <= ACTIVE;
            busy_out         <= 1'b1;
            chip_data_oe_out <= 1'b1;
            bit_cnt          <= '0;
            rx_shift         <= '0;
            tx_shift         <= tx_next_word;
            chip_data_out    <= tx_next_word[DATA_WIDTH-1];
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Deselect: drop a partial word and flag it, never deliver it
            state            <= IDLE;
            busy_out         <= 1'b0;
            chip_data_oe_out <= 1'b0;
            chip_data_out    <= 1'b0;
            bit_cnt          <= '0;
            rx_shift         <= '0;
            if (bit_cnt != '0) begin
              abort_out <= 1'b1;
            end
          end else if (dclk_rise) begin
            rx_shift <= rx_next;
            if (word_end) begin
              rx_data_out   <= rx_next;
              rx_valid_out  <= 1'b1;
              bit_cnt       <= '0;
              tx_shift      <= tx_next_word;
              chip_data_out <= tx_next_word[DATA_WIDTH-1];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (dclk_fall && (bit_cnt != '0)) begin
            // With the counter at zero the freshly loaded MSB stays on CIPO
            tx_shift      <= tx_shift << 1;
            chip_data_out <= tx_shift[DATA_WIDTH-2];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_per.sv
// tb_spi_per: drives spi_per as an SPI mode-0 controller with randomized
// words and timing. A reference model of the TX buffer and expected queues
// for RX words and CIPO words check the DUT.
module tb_spi_per;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk_in;
  logic         rst_n_in;
  logic [W-1:0] tx_data_in;
  logic         tx_load_in;
  logic         tx_empty_out;
  logic [W-1:0] rx_data_out;
  logic         rx_valid_out;
  logic         abort_out;
  logic         busy_out;
  logic         chip_clk_in;
  logic         chip_sel_in;
  logic         chip_data_in;
  logic         chip_data_out;
  logic         chip_data_oe_out;

  spi_per #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .tx_data_in       (tx_data_in),
    .tx_load_in       (tx_load_in),
    .tx_empty_out     (tx_empty_out),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .abort_out        (abort_out),
    .busy_out         (busy_out),
    .chip_clk_in      (chip_clk_in),
    .chip_sel_in      (chip_sel_in),
    .chip_data_in     (chip_data_in),
    .chip_data_out    (chip_data_out),
    .chip_data_oe_out (chip_data_oe_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_tx_q[$];
  int           checks = 0;
  int           errors = 0;
  int           abort_seen = 0;
  int           abort_exp = 0;
  logic [W-1:0] model_buf = '0;
  bit           model_empty = 1'b1;
  bit           prev_valid = 1'b0;
  bit           prev_abort = 1'b0;

  logic [W-1:0] words[4];
  bit           mid_load[4];
  logic [W-1:0] mid_val[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word the controller should see next: buffer if full, else zeros
  function automatic logic [W-1:0] model_consume();
    logic [W-1:0] v;
    v = model_empty ? '0 : model_buf;
    model_empty = 1'b1;
    return v;
  endfunction

  task automatic check_reset_vals();
    check("rst_rx_data", rx_data_out, 0);
    check("rst_rx_valid", rx_valid_out, 0);
    check("rst_abort", abort_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_cipo", chip_data_out, 0);
    check("rst_oe", chip_data_oe_out, 0);
    check("rst_tx_empty", tx_empty_out, 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (rx_valid_out) begin
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got word 0x%0h, expected no rx_valid_out at %0t",
                   rx_data_out, $time);
        end else begin
          check("rx_data", rx_data_out, exp_rx_q.pop_front());
        end
        check("rx_valid_width", prev_valid, 0);
      end
      if (abort_out) begin
        abort_seen++;
        check("abort_width", prev_abort, 0);
      end
      check("oe_vs_busy", chip_data_oe_out, busy_out);
      if (!busy_out) check("cipo_idle", chip_data_out, 0);
    end
    prev_valid = rx_valid_out;
    prev_abort = abort_out;
  end

  // ---------------- driver tasks ----------------
  task automatic tx_load(input logic [W-1:0] d);
    @(negedge clk_in);
    tx_data_in  = d;
    tx_load_in  = 1'b1;
    model_buf   = d;
    model_empty = 1'b0;
    @(negedge clk_in);
    tx_load_in = 1'b0;
    check("tx_empty_after_load", tx_empty_out, 0);
  endtask

  // One CS frame of nwords words with half-period h. stop_after >= 0 ends
  // the frame after that many DCLK rises, either with a CS rise (abort) or
  // with a reset pulse when do_reset is set. start_load strobes tx_load_in
  // in the very cycle the DUT acts on the CS fall.
  task automatic spi_xfer(input int nwords, input int h, input int stop_after,
                          input bit do_reset, input bit start_load,
                          input logic [W-1:0] start_val);
    logic [W-1:0] rx_word;
    logic [W-1:0] nxt;
    int           rises;
    bit           stopped;
    rises   = 0;
    stopped = 1'b0;
    @(negedge clk_in);
    chip_sel_in = 1'b0;
    nxt = model_consume();
    if (start_load) begin
      repeat (S) @(negedge clk_in);
      tx_data_in  = start_val;
      tx_load_in  = 1'b1;
      model_buf   = start_val;
      model_empty = 1'b0;
      @(negedge clk_in);
      tx_load_in = 1'b0;
      repeat (h - S - 1) @(negedge clk_in);
    end else begin
      repeat (h) @(negedge clk_in);
    end
    exp_tx_q.push_back(nxt);
    check("busy_active", busy_out, 1);
    check("tx_empty_start", tx_empty_out, model_empty);
    for (int w = 0; w < nwords; w++) begin
      rx_word = '0;
      for (int b = W - 1; b >= 0; b--) begin
        if (rises == stop_after) begin
          stopped = 1'b1;
          break;
        end
        chip_data_in = words[w][b];
        repeat (h) @(negedge clk_in);
        rx_word = {rx_word[W-2:0], chip_data_out};
        chip_clk_in = 1'b1;
        rises++;
        if (b == 0) begin
          exp_rx_q.push_back(words[w]);
          nxt = model_consume();
          if (w + 1 < nwords) exp_tx_q.push_back(nxt);
        end
        if (b == 4 && mid_load[w]) begin
          tx_data_in  = mid_val[w];
          tx_load_in  = 1'b1;
          model_buf   = mid_val[w];
          model_empty = 1'b0;
          @(negedge clk_in);
          tx_load_in = 1'b0;
          repeat (h - 1) @(negedge clk_in);
        end else begin
          repeat (h) @(negedge clk_in);
        end
        chip_clk_in = 1'b0;
      end
      if (stopped) break;
      check("cipo_word", rx_word, exp_tx_q.pop_front());
    end
    repeat (h) @(negedge clk_in);
    if (stopped) exp_tx_q.delete();
    if (stopped && do_reset) begin
      rst_n_in = 1'b0;
      #1;
      check_reset_vals();
      model_empty = 1'b1;
      exp_rx_q.delete();
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (h) @(negedge clk_in);
      check("busy_after_reset", busy_out, 0);
    end
    chip_sel_in = 1'b1;
    if (stopped && !do_reset) abort_exp++;
    repeat (h) @(negedge clk_in);
    check("busy_idle", busy_out, 0);
    check("oe_idle", chip_data_oe_out, 0);
    check("tx_empty_end", tx_empty_out, model_empty);
    check("abort_count", abort_seen, abort_exp);
  endtask

  task automatic clear_mid();
    for (int i = 0; i < 4; i++) begin
      mid_load[i] = 1'b0;
      mid_val[i]  = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_in     = 1'b0;
    tx_data_in   = '0;
    tx_load_in   = 1'b0;
    chip_clk_in  = 1'b0;
    chip_sel_in  = 1'b1;
    chip_data_in = 1'b0;
    clear_mid();
    repeat (5) @(negedge clk_in);
    check_reset_vals();
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk_in);

    // Load 0xA5, receive 0x3C at 50-cycle half-period
    tx_load(8'hA5);
    words[0] = 8'h3C;
    spi_xfer(1, 50, -1, 1'b0, 1'b0, '0);

    // Empty buffer: controller reads zeros
    words[0] = 8'hFF;
    spi_xfer(1, 8, -1, 1'b0, 1'b0, '0);

    // Two-word burst, buffer reloaded with 0x81 during word one
    tx_load(8'hA5);
    words[0] = 8'h5A;
    words[1] = 8'hC3;
    mid_load[0] = 1'b1;
    mid_val[0]  = 8'h81;
    spi_xfer(2, 10, -1, 1'b0, 1'b0, '0);
    clear_mid();

    // CS raised after three rises: abort
    tx_load(8'h77);
    words[0] = 8'hE1;
    spi_xfer(1, 9, 3, 1'b0, 1'b0, '0);

    // Load coinciding with the CS fall: 0x12 goes out, 0x55 stays buffered
    tx_load(8'h12);
    words[0] = 8'h01;
    words[1] = 8'h80;
    spi_xfer(2, 12, -1, 1'b0, 1'b1, 8'h55);

    // Reset pulse during bit 4, then a clean transfer
    tx_load(8'h3D);
    words[0] = 8'h96;
    spi_xfer(1, 8, 4, 1'b1, 1'b0, '0);
    tx_load(8'hB2);
    words[0] = 8'h4E;
    spi_xfer(1, 8, -1, 1'b0, 1'b0, '0);

    // Randomized frames
    for (int t = 0; t < 10; t++) begin
      int n;
      int h;
      n = $urandom_range(1, 3);
      h = $urandom_range(6, 20);
      for (int i = 0; i < 4; i++) begin
        words[i]    = W'($urandom);
        mid_load[i] = 1'($urandom_range(0, 1));
        mid_val[i]  = W'($urandom);
      end
      if ($urandom_range(0, 1) == 1) tx_load(W'($urandom));
      spi_xfer(n, h, ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : -1,
               1'b0, 1'($urandom_range(0, 3) == 0), W'($urandom));
    end

    repeat (20) @(negedge clk_in);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("abort_total", abort_seen, abort_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
